mem_line_master: RTL and testbench

MEM_LINE_MASTER -- requirements
Module: mem_line_master

---
 rtl/mem_line_master.sv | 121 ++++++++++++
 tb/tb_mem_line_master.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_master.sv
// Single-outstanding cache line fill/write-back master on a waitrequest-style memory bus.
// With no waitrequest and 1-cycle memory, write rsp 2 cycles after handshake and read rsp 3; req_ready only while IDLE.
module mem_line_master #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 128,
   parameter int TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W/8-1:0] req_byte_en,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic [ADDR_W-1:0]   o_addr,
   output logic [DATA_W/8-1:0] o_byte_en,
   output logic [DATA_W-1:0]   o_writedata,
   output logic                o_read,
   output logic                o_write,
   input  logic [DATA_W-1:0]   i_readdata,
   input  logic                i_readdata_valid,
   input  logic                i_waitrequest
);

   typedef enum logic [1:0] {IDLE, CMD, RDWAIT, RESP} state_t;

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   state_t      state;
   logic        write_q;
   logic [15:0] cnt;
   logic        timed_out;
   logic        unused_addr_lsbs;

   assign timed_out        = (cnt == CNT_LAST);
   assign unused_addr_lsbs = ^req_addr[3:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         write_q     <= 1'b0;
         cnt         <= '0;
         req_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         o_addr      <= '0;
         o_byte_en   <= '0;
         o_writedata <= '0;
         o_read      <= 1'b0;
         o_write     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  write_q     <= req_write;
                  o_addr      <= {req_addr[ADDR_W-1:4], 4'b0};
                  o_byte_en   <= req_write ? req_byte_en : '1;
                  o_writedata <= req_write ? req_wdata : '0;
                  o_read      <= ~req_write;
                  o_write     <= req_write;
                  cnt         <= '0;
                  req_ready   <= 1'b0;
                  state       <= CMD;
               end
            end
            CMD: begin
               // acceptance wins over timeout on the final allowed cycle
               if (!i_waitrequest) begin
                  o_read  <= 1'b0;
                  o_write <= 1'b0;
                  cnt     <= '0;
                  if (write_q) begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b0;
                     rsp_rdata <= '0;
                     state     <= RESP;
                  end else begin
                     state <= RDWAIT;
                  end
               end else if (timed_out) begin
                  o_read    <= 1'b0;
                  o_write   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
                  state     <= RESP;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            RDWAIT: begin
               if (i_readdata_valid) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= i_readdata;
                  state     <= RESP;
               end else if (timed_out) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
                  state     <= RESP;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            RESP: begin
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_line_master.sv
// Directed bench for mem_line_master: a transaction-timing model derived from the bus rules is checked every cycle.
module tb_mem_line_master;

   localparam int AW = 32;
   localparam int DW = 128;
   localparam int BW = DW / 8;
   localparam int TO = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req_valid, req_ready, req_write;
   logic [AW-1:0] req_addr;
   logic [BW-1:0] req_byte_en;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid, rsp_err;
   logic [DW-1:0] rsp_rdata;
   logic [AW-1:0] o_addr;
   logic [BW-1:0] o_byte_en;
   logic [DW-1:0] o_writedata;
   logic          o_read, o_write;
   logic [DW-1:0] i_readdata;
   logic          i_readdata_valid, i_waitrequest;

   always #5 clk = ~clk;

   mem_line_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_byte_en(req_byte_en), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .o_addr(o_addr), .o_byte_en(o_byte_en), .o_writedata(o_writedata),
      .o_read(o_read), .o_write(o_write),
      .i_readdata(i_readdata), .i_readdata_valid(i_readdata_valid),
      .i_waitrequest(i_waitrequest)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // Model of the transaction in flight, expressed as absolute cycle numbers.
   bit            active = 1'b0;
   int            hs = 0, cmd_first = 0, cmd_last = 0, rsp_at = 0;
   bit            m_write = 1'b0, m_err = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [BW-1:0] m_be = '0;
   logic [DW-1:0] m_wd = '0, m_rd = '0;
   bit            hold_err = 1'b0;
   logic [DW-1:0] hold_data = '0;

   int            obs_cmd_cnt = 0, obs_rsp_cnt = 0, obs_rsp_cyc = 0;
   logic [AW-1:0] obs_addr = '0;
   logic [BW-1:0] obs_be = '0;
   logic [DW-1:0] obs_rdata = '0;
   bit            obs_err = 1'b0;

   bit in_cmd, busy, rv;

   always @(negedge clk) begin
      if (!rst) begin
         hold_err  = 1'b0;
         hold_data = '0;
         chk("rst_o_read", 128'(o_read), 128'd0);
         chk("rst_o_write", 128'(o_write), 128'd0);
         chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
         chk("rst_rsp_err", 128'(rsp_err), 128'd0);
         chk("rst_rsp_rdata", rsp_rdata, 128'd0);
         chk("rst_o_addr", 128'(o_addr), 128'd0);
      end else begin
         in_cmd = active && cyc >= cmd_first && cyc <= cmd_last;
         busy   = active && cyc > hs && cyc <= rsp_at;
         rv     = active && cyc == rsp_at;
         chk("req_ready", 128'(req_ready), 128'(!busy));
         chk("o_read", 128'(o_read), 128'(in_cmd && !m_write));
         chk("o_write", 128'(o_write), 128'(in_cmd && m_write));
         if (in_cmd) begin
            chk("o_addr", 128'(o_addr), 128'(m_addr));
            chk("o_byte_en", 128'(o_byte_en), 128'(m_be));
            chk("o_writedata", o_writedata, m_wd);
         end
         chk("rsp_valid", 128'(rsp_valid), 128'(rv));
         if (rv) begin
            hold_err  = m_err;
            hold_data = m_rd;
         end
         chk("rsp_err", 128'(rsp_err), 128'(hold_err));
         chk("rsp_rdata", rsp_rdata, hold_data);
         if (o_read || o_write) begin
            obs_cmd_cnt++;
            obs_addr = o_addr;
            obs_be   = o_byte_en;
         end
         if (rsp_valid) begin
            obs_rsp_cnt++;
            obs_rsp_cyc = cyc;
            obs_err     = rsp_err;
            obs_rdata   = rsp_rdata;
         end
      end
   end

   function automatic logic [DW-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // wcyc: waitrequest-high cycles in CMD (>= TO means stuck); lat: RDWAIT cycle index of data (-1 = never);
   // abort: cycle offset from handshake at which reset is pulsed (-1 = none).
   task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [BW-1:0] be,
                          input logic [DW-1:0] d, input int wcyc, input int lat, input int abort);
      int rd_start, data_at, junk_until, endc;
      bit done;
      rd_start = -1;
      data_at  = -1;
      done     = 1'b0;
      hs        = cyc;
      cmd_first = hs + 1;
      m_write   = wr;
      m_addr    = {addr[AW-1:4], 4'b0};
      m_be      = wr ? be : '1;
      m_wd      = wr ? d : '0;
      if (wcyc >= TO) begin
         cmd_last = hs + TO;
         rsp_at   = cmd_last + 1;
         m_err    = 1'b1;
         m_rd     = '0;
      end else begin
         cmd_last = cmd_first + wcyc;
         if (wr) begin
            rsp_at = cmd_last + 1;
            m_err  = 1'b0;
            m_rd   = '0;
         end else begin
            rd_start = cmd_last + 1;
            if (lat >= 0) data_at = rd_start + lat;
            if (lat >= 0 && lat < TO) begin
               rsp_at = data_at + 1;
               m_err  = 1'b0;
               m_rd   = d;
            end else begin
               rsp_at = rd_start + TO;
               m_err  = 1'b1;
               m_rd   = '0;
            end
         end
      end
      junk_until = (rd_start >= 0) ? rd_start - 1 : rsp_at;
      endc       = (data_at > rsp_at) ? data_at : rsp_at;
      active     = 1'b1;
      while (!done && cyc <= endc) begin
         if (abort >= 0 && cyc == hs + abort) begin
            rst    = 1'b0;
            active = 1'b0;
            #1;
            chk("async_rsp_err", 128'(rsp_err), 128'd0);
            chk("async_o_read", 128'(o_read), 128'd0);
            chk("async_rsp_valid", 128'(rsp_valid), 128'd0);
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b1;
            chk("ready_after_rst", 128'(req_ready), 128'd1);
            done = 1'b1;
         end else begin
            req_valid = (cyc == hs);
            if (cyc == hs) begin
               req_write   = wr;
               req_addr    = addr;
               req_byte_en = be;
               req_wdata   = d;
            end else begin
               req_write   = 1'($urandom);
               req_addr    = $urandom;
               req_byte_en = 16'($urandom);
               req_wdata   = rnd128();
            end
            if (cyc >= cmd_first && cyc <= cmd_last) i_waitrequest = (cyc < cmd_first + wcyc);
            else                                     i_waitrequest = 1'($urandom);
            i_readdata_valid = (cyc == data_at) || (cyc <= junk_until);
            i_readdata       = (cyc == data_at) ? d : rnd128();
            @(posedge clk);
            #1;
         end
      end
      req_valid        = 1'b0;
      i_readdata_valid = 1'b0;
      i_waitrequest    = 1'b0;
   endtask

   typedef struct {
      bit            wr;
      logic [AW-1:0] addr;
      logic [BW-1:0] be;
      logic [DW-1:0] d;
      int            w;
      int            lat;
   } vec_t;

   vec_t vecs[8];
   int   c0, r0;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1'b0, 32'h0000_1008, 16'h0000, 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0, 0, 0};
      vecs[1] = '{1'b1, 32'h0000_2010, 16'hF00F, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 0, 0};
      vecs[2] = '{1'b0, 32'h0000_301F, 16'h0000, 128'hDEAD_BEEF_0000_0001_DEAD_BEEF_0000_0002, 2, 1};
      vecs[3] = '{1'b1, 32'h0000_4000, 16'hFFFF, 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000, 63, 0};
      vecs[4] = '{1'b0, 32'h0000_500C, 16'h0000, 128'h0BAD_F00D_0BAD_F00D_0BAD_F00D_0BAD_F00D, 63, 63};
      vecs[5] = '{1'b1, 32'h0000_6008, 16'h0001, 128'h0000_0000_0000_0000_0000_0000_0000_00AB, 1, 0};
      vecs[6] = '{1'b0, 32'h7FFF_FFF0, 16'h0000, 128'h8000_0000_0000_0000_0000_0000_0000_0001, 0, 5};
      vecs[7] = '{1'b0, 32'hFFFF_FFFF, 16'h0000, 128'hCAFE_BABE_CAFE_BABE_CAFE_BABE_CAFE_BABE, 1, 0};

      req_valid = 0; req_write = 0; req_addr = '0; req_byte_en = '0; req_wdata = '0;
      i_readdata = '0; i_readdata_valid = 0; i_waitrequest = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;

      // line fill, immediate accept, 1-cycle memory; starts on the first edge out of reset
      c0 = obs_cmd_cnt; r0 = obs_rsp_cnt;
      run_txn(1'b0, 32'h0000_1238, 16'h0, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 0, 0, -1);
      chk("rd_rsp_cycle", 128'(obs_rsp_cyc - hs), 128'd3);
      chk("rd_o_addr", 128'(obs_addr), 128'h1230);
      chk("rd_cmd_cycles", 128'(obs_cmd_cnt - c0), 128'd1);
      chk("rd_data", obs_rdata, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
      chk("rd_err", 128'(obs_err), 128'd0);

      // write-back held off by waitrequest for 3 cycles
      c0 = obs_cmd_cnt;
      run_txn(1'b1, 32'h0000_0040, 16'h00FF, 128'hFEDC_BA98_7654_3210_FEDC_BA98_7654_3210, 3, 0, -1);
      chk("wr_cmd_cycles", 128'(obs_cmd_cnt - c0), 128'd4);
      chk("wr_rsp_cycle", 128'(obs_rsp_cyc - hs), 128'd5);
      chk("wr_byte_en", 128'(obs_be), 128'h00FF);
      chk("wr_err", 128'(obs_err), 128'd0);

      // memory never answers; late data arrives 3 cycles after the abort
      r0 = obs_rsp_cnt;
      run_txn(1'b0, 32'h0000_2000, 16'h0, 128'h5555_5555_5555_5555_5555_5555_5555_5555, 0, TO + 3, -1);
      chk("rdto_rsp_cycle", 128'(obs_rsp_cyc - hs), 128'(2 + TO));
      chk("rdto_err", 128'(obs_err), 128'd1);
      chk("rdto_data", obs_rdata, 128'd0);
      chk("rdto_rsp_count", 128'(obs_rsp_cnt - r0), 128'd1);

      // waitrequest stuck high
      c0 = obs_cmd_cnt;
      run_txn(1'b0, 32'h0000_3004, 16'h0, 128'h0, 1000, 0, -1);
      chk("stuck_cmd_cycles", 128'(obs_cmd_cnt - c0), 128'(TO));
      chk("stuck_rsp_cycle", 128'(obs_rsp_cyc - hs), 128'(TO + 1));
      chk("stuck_err", 128'(obs_err), 128'd1);

      // reset pulsed while waiting for read data
      r0 = obs_rsp_cnt;
      run_txn(1'b0, 32'h0000_5000, 16'h0, 128'h0, 0, -1, 4);
      chk("abort_no_rsp", 128'(obs_rsp_cnt - r0), 128'd0);

      // back-to-back mixed traffic including last-cycle accept/data boundaries
      r0 = obs_rsp_cnt;
      for (int i = 0; i < 8; i++)
         run_txn(vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].d, vecs[i].w, vecs[i].lat, -1);
      chk("b2b_rsp_count", 128'(obs_rsp_cnt - r0), 128'd8);
      chk("b2b_last_data", obs_rdata, 128'hCAFE_BABE_CAFE_BABE_CAFE_BABE_CAFE_BABE);
      chk("b2b_last_addr", 128'(obs_addr), 128'hFFFF_FFF0);

      repeat (3) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
